// File: rtl/axi_lite_ipif_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to IPIF bridge: response codes,
// FSM state encoding and the acknowledge-timeout counter width.
package axi_lite_ipif_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int TMO_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_WRESP = 2'd2,
        ST_RRESP = 2'd3
    } state_t;

endpackage

// File: rtl/axi_lite_ipif_bridge_if.sv
// AXI4-Lite slave channels plus the IPIF request/acknowledge signals.
// The bridge uses the slave view; the interconnect/register side uses master.
interface axi_lite_ipif_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    logic [ADDR_W-1:0]   Bus2IP_Addr;
    logic                Bus2IP_CS;
    logic                Bus2IP_RNW;
    logic [DATA_W-1:0]   Bus2IP_Data;
    logic [DATA_W/8-1:0] Bus2IP_BE;
    logic [DATA_W-1:0]   IP2Bus_Data;
    logic                IP2Bus_RdAck;
    logic                IP2Bus_WrAck;
    logic                IP2Bus_Error;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
               IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
               Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
               IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
               Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE
    );
endinterface

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave to single-beat IPIF bridge: address decode, read/write
// arbitration, acknowledge timeout and AXI response generation.
module axi_lite_ipif_bridge
    import axi_lite_ipif_bridge_pkg::*;
#(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'hFFFF_FFFF,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h0000_0000,
    parameter int                            C_TIMEOUT          = 64
) (
    input logic S_AXI_ACLK,
    input logic S_AXI_ARESET,
    axi_lite_ipif_bridge_if.slave bus
);

    localparam int                BE_W     = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(C_TIMEOUT - 1);

    state_t                          state_q, state_d;
    logic                            last_was_read_q, last_was_read_d;
    logic                            cs_q, cs_d;
    logic                            rnw_q, rnw_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [BE_W-1:0]                 be_q, be_d;
    logic [1:0]                      resp_q, resp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [TMO_W-1:0]                cnt_q, cnt_d;

    logic                            wr_req, rd_req, grant_rd, grant_wr, ack, decoded;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   req_addr;

    // Grants are only offered from IDLE; on a tie the side that lost last time wins.
    always_comb begin
        wr_req   = bus.S_AXI_AWVALID && bus.S_AXI_WVALID;
        rd_req   = bus.S_AXI_ARVALID;
        grant_rd = (state_q == ST_IDLE) && !S_AXI_ARESET && rd_req
                   && (!wr_req || !last_was_read_q);
        grant_wr = (state_q == ST_IDLE) && !S_AXI_ARESET && wr_req && !grant_rd;
        req_addr = grant_rd ? bus.S_AXI_ARADDR : bus.S_AXI_AWADDR;
        decoded  = (req_addr >= C_BASEADDR) && (req_addr <= C_HIGHADDR);
        ack      = rnw_q ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;
    end

    always_comb begin
        state_d         = state_q;
        last_was_read_d = last_was_read_q;
        cs_d            = cs_q;
        rnw_d           = rnw_q;
        addr_d          = addr_q;
        data_d          = data_q;
        be_d            = be_q;
        resp_d          = resp_q;
        rdata_d         = rdata_q;
        cnt_d           = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_rd || grant_wr) begin
                    last_was_read_d = grant_rd;
                    rnw_d           = grant_rd;
                    addr_d          = req_addr;
                    be_d            = grant_rd ? '1 : bus.S_AXI_WSTRB;
                    cnt_d           = '0;
                    if (grant_wr) data_d = bus.S_AXI_WDATA;
                    if (decoded) begin
                        cs_d    = 1'b1;
                        state_d = ST_XFER;
                    end else begin
                        resp_d  = RESP_DECERR;
                        rdata_d = '0;
                        state_d = grant_rd ? ST_RRESP : ST_WRESP;
                    end
                end
            end
            ST_XFER: begin
                // An ack arriving on the terminal count still completes normally.
                if (ack) begin
                    cs_d    = 1'b0;
                    resp_d  = bus.IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
                    rdata_d = rnw_q ? bus.IP2Bus_Data : '0;
                    state_d = rnw_q ? ST_RRESP : ST_WRESP;
                end else if (cnt_q == TMO_LAST) begin
                    cs_d    = 1'b0;
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = rnw_q ? ST_RRESP : ST_WRESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRESP: if (bus.S_AXI_BREADY) state_d = ST_IDLE;
            ST_RRESP: if (bus.S_AXI_RREADY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q         <= ST_IDLE;
            last_was_read_q <= 1'b0;
            cs_q            <= 1'b0;
            rnw_q           <= 1'b1;
            addr_q          <= '0;
            data_q          <= '0;
            be_q            <= '0;
            resp_q          <= RESP_OKAY;
            rdata_q         <= '0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            last_was_read_q <= last_was_read_d;
            cs_q            <= cs_d;
            rnw_q           <= rnw_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            be_q            <= be_d;
            resp_q          <= resp_d;
            rdata_q         <= rdata_d;
            cnt_q           <= cnt_d;
        end
    end

    // The strobe drops in the ack cycle so a registered-ack slave sees one request.
    assign bus.Bus2IP_CS     = cs_q & ~(bus.IP2Bus_RdAck | bus.IP2Bus_WrAck);
    assign bus.Bus2IP_RNW    = rnw_q;
    assign bus.Bus2IP_Addr   = addr_q;
    assign bus.Bus2IP_Data   = data_q;
    assign bus.Bus2IP_BE     = be_q;
    assign bus.S_AXI_AWREADY = grant_wr;
    assign bus.S_AXI_WREADY  = grant_wr;
    assign bus.S_AXI_ARREADY = grant_rd;
    assign bus.S_AXI_BVALID  = (state_q == ST_WRESP);
    assign bus.S_AXI_BRESP   = resp_q;
    assign bus.S_AXI_RVALID  = (state_q == ST_RRESP);
    assign bus.S_AXI_RRESP   = resp_q;
    assign bus.S_AXI_RDATA   = rdata_q;

endmodule
